// File: rtl/ecap5_dproc_pkg.sv
// Shared encodings for the execute stage: ALU op codes, branch conditions,
// the registered result entry and the branch-condition evaluator.
package ecap5_dproc_pkg;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_XOR   = 3'd1;
    localparam logic [2:0] ALU_OR    = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_SLTU  = 3'd5;
    localparam logic [2:0] ALU_SHIFT = 3'd6;

    localparam logic [2:0] BRANCH_NONE   = 3'd0;
    localparam logic [2:0] BRANCH_EQ     = 3'd1;
    localparam logic [2:0] BRANCH_NE     = 3'd2;
    localparam logic [2:0] BRANCH_LT     = 3'd3;
    localparam logic [2:0] BRANCH_GE     = 3'd4;
    localparam logic [2:0] BRANCH_LTU    = 3'd5;
    localparam logic [2:0] BRANCH_GEU    = 3'd6;
    localparam logic [2:0] BRANCH_ALWAYS = 3'd7;

    typedef struct packed {
        logic [31:0] alu_result;
        logic        enable;
        logic        write;
        logic [31:0] write_data;
        logic [3:0]  sel;
        logic        unsigned_load;
        logic        reg_write;
        logic [4:0]  reg_addr;
    } exec_entry_t;

    function automatic logic branch_taken(input logic [2:0] cond,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic taken;
        taken = 1'b0;
        case (cond)
            BRANCH_EQ:     taken = (a == b);
            BRANCH_NE:     taken = (a != b);
            BRANCH_LT:     taken = ($signed(a) < $signed(b));
            BRANCH_GE:     taken = ($signed(a) >= $signed(b));
            BRANCH_LTU:    taken = (a < b);
            BRANCH_GEU:    taken = (a >= b);
            BRANCH_ALWAYS: taken = 1'b1;
            default:       taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage. A single right shifter serves
// both directions by bit-reversing the operand around it for left shifts.
module alu
    import ecap5_dproc_pkg::*;
(
    input  logic [2:0]  op,
    input  logic        sub,
    input  logic        shift_left,
    input  logic        signed_shift,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [31:0] result
);

    logic [31:0] shift_in;
    logic [31:0] shift_raw;
    logic [31:0] shift_out;
    logic [4:0]  shamt;
    logic        fill;

    assign shamt = operand2[4:0];
    assign fill  = signed_shift & ~shift_left & operand1[31];

    for (genvar gi = 0; gi < 32; gi++) begin : gen_reverse
        assign shift_in[gi]  = shift_left ? operand1[31 - gi]  : operand1[gi];
        assign shift_out[gi] = shift_left ? shift_raw[31 - gi] : shift_raw[gi];
    end

    // Vacated upper bits are filled with the sign only for arithmetic right shifts.
    assign shift_raw = (shift_in >> shamt) | (fill ? ~(32'hFFFF_FFFF >> shamt) : 32'd0);

    always_comb begin
        result = 32'd0;
        case (op)
            ALU_ADD:   result = sub ? (operand1 - operand2) : (operand1 + operand2);
            ALU_XOR:   result = operand1 ^ operand2;
            ALU_OR:    result = operand1 | operand2;
            ALU_AND:   result = operand1 & operand2;
            ALU_SLT:   result = {31'd0, $signed(operand1) < $signed(operand2)};
            ALU_SLTU:  result = {31'd0, operand1 < operand2};
            ALU_SHIFT: result = shift_out;
            default:   result = 32'd0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// Execute stage: ALU + branch resolution, registered toward load/store.
// Optional EXECUTE_SKID_BUFFER_EN adds a skid entry so input_ready_o is registered.
module execute
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] alu_operand1_i,
    input  logic [31:0] alu_operand2_i,
    input  logic [2:0]  alu_op_i,
    input  logic        alu_sub_i,
    input  logic        alu_shift_left_i,
    input  logic        alu_signed_shift_i,
    input  logic [2:0]  branch_cond_i,
    input  logic [31:0] branch_offset_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic [31:0] ls_write_data_i,
    input  logic [3:0]  ls_sel_i,
    input  logic        ls_unsigned_load_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] alu_result_o,
    output logic        enable_o,
    output logic        write_o,
    output logic [31:0] write_data_o,
    output logic [3:0]  sel_o,
    output logic        unsigned_load_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic        branch_o,
    output logic [31:0] branch_target_o
);

    logic [31:0] alu_result;
    exec_entry_t in_entry;
    logic        in_branch;
    logic [31:0] in_target;
    logic        accept;

    exec_entry_t out_reg;
    logic        out_valid_reg;
    logic        branch_reg;
    logic [31:0] target_reg;

    alu u_alu (
        .op           (alu_op_i),
        .sub          (alu_sub_i),
        .shift_left   (alu_shift_left_i),
        .signed_shift (alu_signed_shift_i),
        .operand1     (alu_operand1_i),
        .operand2     (alu_operand2_i),
        .result       (alu_result)
    );

    assign in_entry = '{
        alu_result:    alu_result,
        enable:        ls_enable_i,
        write:         ls_write_i,
        write_data:    ls_write_data_i,
        sel:           ls_sel_i,
        unsigned_load: ls_unsigned_load_i,
        reg_write:     reg_write_i,
        reg_addr:      reg_addr_i
    };
    assign in_branch = branch_taken(branch_cond_i, alu_operand1_i, alu_operand2_i);
    assign in_target = pc_i + branch_offset_i;

`ifdef EXECUTE_SKID_BUFFER_EN
    exec_entry_t skid_reg;
    logic        skid_valid_reg;
    logic        skid_branch_reg;
    logic [31:0] skid_target_reg;
    logic        out_free;

    // Ready only depends on skid occupancy, so it is a flop output.
    assign input_ready_o = ~skid_valid_reg;
    assign accept        = input_valid_i & input_ready_o;
    assign out_free      = ~out_valid_reg | output_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_reg         <= '0;
            out_valid_reg   <= 1'b0;
            branch_reg      <= 1'b0;
            target_reg      <= 32'd0;
            skid_reg        <= '0;
            skid_valid_reg  <= 1'b0;
            skid_branch_reg <= 1'b0;
            skid_target_reg <= 32'd0;
        end else begin
            branch_reg <= 1'b0;
            if (out_free) begin
                // Skid holds the older instruction, so it drains first.
                if (skid_valid_reg) begin
                    out_reg        <= skid_reg;
                    out_valid_reg  <= 1'b1;
                    branch_reg     <= skid_branch_reg;
                    skid_valid_reg <= 1'b0;
                    if (skid_branch_reg) begin
                        target_reg <= skid_target_reg;
                    end
                end else if (accept) begin
                    out_reg       <= in_entry;
                    out_valid_reg <= 1'b1;
                    branch_reg    <= in_branch;
                    if (in_branch) begin
                        target_reg <= in_target;
                    end
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end else if (accept) begin
                skid_reg        <= in_entry;
                skid_valid_reg  <= 1'b1;
                skid_branch_reg <= in_branch;
                skid_target_reg <= in_target;
            end
        end
    end
`else
    assign input_ready_o = ~out_valid_reg | output_ready_i;
    assign accept        = input_valid_i & input_ready_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            branch_reg    <= 1'b0;
            target_reg    <= 32'd0;
        end else begin
            // branch_reg is a pulse: it clears even while the output stalls.
            branch_reg <= accept & in_branch;
            if (accept) begin
                out_reg       <= in_entry;
                out_valid_reg <= 1'b1;
                if (in_branch) begin
                    target_reg <= in_target;
                end
            end else if (output_ready_i) begin
                out_valid_reg <= 1'b0;
            end
        end
    end
`endif

    assign output_valid_o  = out_valid_reg;
    assign alu_result_o    = out_reg.alu_result;
    assign enable_o        = out_reg.enable;
    assign write_o         = out_reg.write;
    assign write_data_o    = out_reg.write_data;
    assign sel_o           = out_reg.sel;
    assign unsigned_load_o = out_reg.unsigned_load;
    assign reg_write_o     = out_reg.reg_write;
    assign reg_addr_o      = out_reg.reg_addr;
    assign branch_o        = branch_reg;
    assign branch_target_o = target_reg;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed scenarios plus a randomized run
// scored against a queue-based reference model.
module tb_execute;
    import ecap5_dproc_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic [31:0] pc_i;
    logic [31:0] alu_operand1_i;
    logic [31:0] alu_operand2_i;
    logic [2:0]  alu_op_i;
    logic        alu_sub_i;
    logic        alu_shift_left_i;
    logic        alu_signed_shift_i;
    logic [2:0]  branch_cond_i;
    logic [31:0] branch_offset_i;
    logic        ls_enable_i;
    logic        ls_write_i;
    logic [31:0] ls_write_data_i;
    logic [3:0]  ls_sel_i;
    logic        ls_unsigned_load_i;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic        output_ready_i;
    logic        output_valid_o;
    logic [31:0] alu_result_o;
    logic        enable_o;
    logic        write_o;
    logic [31:0] write_data_o;
    logic [3:0]  sel_o;
    logic        unsigned_load_o;
    logic        reg_write_o;
    logic [4:0]  reg_addr_o;
    logic        branch_o;
    logic [31:0] branch_target_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [76:0] payload;
        logic        br;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];

    execute dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .input_valid_i      (input_valid_i),
        .input_ready_o      (input_ready_o),
        .pc_i               (pc_i),
        .alu_operand1_i     (alu_operand1_i),
        .alu_operand2_i     (alu_operand2_i),
        .alu_op_i           (alu_op_i),
        .alu_sub_i          (alu_sub_i),
        .alu_shift_left_i   (alu_shift_left_i),
        .alu_signed_shift_i (alu_signed_shift_i),
        .branch_cond_i      (branch_cond_i),
        .branch_offset_i    (branch_offset_i),
        .ls_enable_i        (ls_enable_i),
        .ls_write_i         (ls_write_i),
        .ls_write_data_i    (ls_write_data_i),
        .ls_sel_i           (ls_sel_i),
        .ls_unsigned_load_i (ls_unsigned_load_i),
        .reg_write_i        (reg_write_i),
        .reg_addr_i         (reg_addr_i),
        .output_ready_i     (output_ready_i),
        .output_valid_o     (output_valid_o),
        .alu_result_o       (alu_result_o),
        .enable_o           (enable_o),
        .write_o            (write_o),
        .write_data_o       (write_data_o),
        .sel_o              (sel_o),
        .unsigned_load_o    (unsigned_load_o),
        .reg_write_o        (reg_write_o),
        .reg_addr_o         (reg_addr_o),
        .branch_o           (branch_o),
        .branch_target_o    (branch_target_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic sub,
                                              input logic sl, input logic ss,
                                              input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            ALU_ADD:   return sub ? a - b : a + b;
            ALU_XOR:   return a ^ b;
            ALU_OR:    return a | b;
            ALU_AND:   return a & b;
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_SHIFT: begin
                if (sl)      return a << sh;
                else if (ss) return $signed(a) >>> sh;
                else         return a >> sh;
            end
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic model_branch(input logic [2:0] cond,
                                          input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        case (cond)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return sa < sb;
            3'd4:    return sa >= sb;
            3'd5:    return a < b;
            3'd6:    return a >= b;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [76:0] out_payload();
        return {alu_result_o, enable_o, write_o, write_data_o, sel_o,
                unsigned_load_o, reg_write_o, reg_addr_o};
    endfunction

    function automatic logic [76:0] model_payload();
        return {model_alu(alu_op_i, alu_sub_i, alu_shift_left_i, alu_signed_shift_i,
                          alu_operand1_i, alu_operand2_i),
                ls_enable_i, ls_write_i, ls_write_data_i, ls_sel_i,
                ls_unsigned_load_i, reg_write_i, reg_addr_i};
    endfunction

    // Drive one instruction at the falling edge and return just after the next rising edge.
    task automatic issue(input logic [2:0] op, input logic sub, input logic sl, input logic ss,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] cond, input logic [31:0] pc, input logic [31:0] off);
        @(negedge clk_i);
        alu_op_i           = op;
        alu_sub_i          = sub;
        alu_shift_left_i   = sl;
        alu_signed_shift_i = ss;
        alu_operand1_i     = a;
        alu_operand2_i     = b;
        branch_cond_i      = cond;
        pc_i               = pc;
        branch_offset_i    = off;
        ls_enable_i        = 1'b1;
        ls_write_i         = 1'b0;
        ls_write_data_i    = 32'hA5A5_0000 ^ a;
        ls_sel_i           = 4'hF;
        ls_unsigned_load_i = 1'b0;
        reg_write_i        = 1'b1;
        reg_addr_i         = 5'd7;
        input_valid_i      = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        @(negedge clk_i);
        input_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if ({output_valid_o, alu_result_o, enable_o, write_o, write_data_o, sel_o, unsigned_load_o,
             reg_write_o, reg_addr_o, branch_o, branch_target_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b result=%h branch=%b target=%h required all zero",
                     output_valid_o, alu_result_o, branch_o, branch_target_o);
        end
        n_checks++;
        if (input_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", input_ready_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        $display("reset released");
    endtask

    task automatic test_add_wrap();
        logic [31:0] exp;
        output_ready_i = 1'b1;
        issue(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, BRANCH_NONE, 32'h0, 32'h0);
        exp = model_alu(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        n_checks++;
        if (output_valid_o !== 1'b1 || alu_result_o !== exp) begin
            n_fail++;
            $display("FAIL add_wrap: got valid=%b result=%h required valid=1 result=%h",
                     output_valid_o, alu_result_o, exp);
        end
        $display("add_wrap: result=%h", alu_result_o);
        issue(ALU_ADD, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5, BRANCH_NONE, 32'h0, 32'h0);
        exp = model_alu(ALU_ADD, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
        n_checks++;
        if (alu_result_o !== exp) begin
            n_fail++;
            $display("FAIL sub_wrap: got %h required %h", alu_result_o, exp);
        end
        idle();
        @(posedge clk_i);
        #1;
        n_checks++;
        if (output_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_valid: got %b required 0", output_valid_o);
        end
    endtask

    task automatic test_shift();
        logic [31:0] exp;
        issue(ALU_SHIFT, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4, BRANCH_NONE, 32'h0, 32'h0);
        exp = model_alu(ALU_SHIFT, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4);
        n_checks++;
        if (alu_result_o !== exp) begin
            n_fail++;
            $display("FAIL shift_sra: got %h required %h", alu_result_o, exp);
        end
        $display("shift_sra: result=%h", alu_result_o);
        issue(ALU_SHIFT, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, BRANCH_NONE, 32'h0, 32'h0);
        exp = model_alu(ALU_SHIFT, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4);
        n_checks++;
        if (alu_result_o !== exp) begin
            n_fail++;
            $display("FAIL shift_srl: got %h required %h", alu_result_o, exp);
        end
        $display("shift_srl: result=%h", alu_result_o);
        issue(ALU_SHIFT, 1'b0, 1'b1, 1'b1, 32'h1234_5679, 32'hFFFF_FFE3, BRANCH_NONE, 32'h0, 32'h0);
        exp = model_alu(ALU_SHIFT, 1'b0, 1'b1, 1'b1, 32'h1234_5679, 32'hFFFF_FFE3);
        n_checks++;
        if (alu_result_o !== exp) begin
            n_fail++;
            $display("FAIL shift_sll: got %h required %h", alu_result_o, exp);
        end
        $display("shift_sll: result=%h", alu_result_o);
    endtask

    task automatic test_slt();
        issue(ALU_SLT, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, BRANCH_NONE, 32'h0, 32'h0);
        n_checks++;
        if (alu_result_o !== model_alu(ALU_SLT, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1)) begin
            n_fail++;
            $display("FAIL slt: got %h required 1", alu_result_o);
        end
        $display("slt: result=%h", alu_result_o);
        issue(ALU_SLTU, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, BRANCH_NONE, 32'h0, 32'h0);
        n_checks++;
        if (alu_result_o !== model_alu(ALU_SLTU, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1)) begin
            n_fail++;
            $display("FAIL sltu: got %h required 0", alu_result_o);
        end
        $display("sltu: result=%h", alu_result_o);
    endtask

    task automatic test_branch();
        logic [31:0] tgt;
        tgt = 32'h100 + 32'hFFFF_FFF8;
        issue(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFB, 32'd3, BRANCH_LT, 32'h100, 32'hFFFF_FFF8);
        n_checks++;
        if (branch_o !== model_branch(BRANCH_LT, 32'hFFFF_FFFB, 32'd3) || branch_target_o !== tgt) begin
            n_fail++;
            $display("FAIL branch_lt: got branch=%b target=%h required branch=1 target=%h",
                     branch_o, branch_target_o, tgt);
        end
        $display("branch_lt: branch=%b target=%h", branch_o, branch_target_o);
        issue(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, BRANCH_NONE, 32'h200, 32'h40);
        n_checks++;
        if (branch_o !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_none: got %b required 0", branch_o);
        end
        idle();
        @(posedge clk_i);
        #1;
        n_checks++;
        if (branch_o !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_idle: got %b required 0", branch_o);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] tgt_b;
        exp_a = model_alu(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
        exp_b = model_alu(ALU_XOR, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        tgt_b = 32'h400 + 32'h20;
        output_ready_i = 1'b1;
        issue(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, BRANCH_NONE, 32'h300, 32'h0);
        output_ready_i = 1'b0;
        issue(ALU_XOR, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, BRANCH_ALWAYS, 32'h400, 32'h20);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk_i);
                #1;
            end
            n_checks++;
            if (output_valid_o !== 1'b1 || alu_result_o !== exp_a) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%b result=%h required valid=1 result=%h",
                         i, output_valid_o, alu_result_o, exp_a);
            end
            n_checks++;
            if (input_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %b required 0", i, input_ready_o);
            end
            n_checks++;
            if (branch_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_branch[%0d]: got %b required 0", i, branch_o);
            end
            $display("stall cycle %0d: result=%h ready=%b", i, alu_result_o, input_ready_o);
        end
        @(negedge clk_i);
        output_ready_i = 1'b1;
        #1;
        n_checks++;
        if (input_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got %b required 1", input_ready_o);
        end
        @(posedge clk_i);
        #1;
        n_checks++;
        if (output_valid_o !== 1'b1 || alu_result_o !== exp_b) begin
            n_fail++;
            $display("FAIL no_bubble: got valid=%b result=%h required valid=1 result=%h",
                     output_valid_o, alu_result_o, exp_b);
        end
        n_checks++;
        if (branch_o !== 1'b1 || branch_target_o !== tgt_b) begin
            n_fail++;
            $display("FAIL release_branch: got branch=%b target=%h required branch=1 target=%h",
                     branch_o, branch_target_o, tgt_b);
        end
        $display("release: result=%h branch=%b", alu_result_o, branch_o);
        idle();
        @(posedge clk_i);
        #1;
        n_checks++;
        if (output_valid_o !== 1'b0 || branch_o !== 1'b0) begin
            n_fail++;
            $display("FAIL after_release: got valid=%b branch=%b required 0 0", output_valid_o, branch_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        output_ready_i = 1'b0;
        issue(ALU_OR, 1'b0, 1'b0, 1'b0, 32'h1111_0000, 32'h0000_2222, BRANCH_ALWAYS, 32'h500, 32'h4);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({output_valid_o, alu_result_o, enable_o, write_o, write_data_o, sel_o, unsigned_load_o,
             reg_write_o, reg_addr_o, branch_o, branch_target_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_stall_reset: got valid=%b result=%h target=%h required all zero",
                     output_valid_o, alu_result_o, branch_target_o);
        end
        $display("mid-stall reset: valid=%b result=%h", output_valid_o, alu_result_o);
        @(negedge clk_i);
        rst_i          = 1'b1;
        input_valid_i  = 1'b0;
        output_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (output_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_valid: got %b required 0", output_valid_o);
        end
    endtask

    task automatic test_random();
        logic prev_valid;
        logic prev_fire;
        logic fresh;
        logic exp_br;
        logic acc;
        logic fire;
        exp_t e;
        int   n_tx;
        n_tx = 0;
        q.delete();
        @(negedge clk_i);
        prev_valid = output_valid_o;
        prev_fire  = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks++;
            if (output_valid_o !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_valid cyc %0d: got %b required %b", cyc, output_valid_o, q.size() != 0);
            end
            fresh  = output_valid_o && (!prev_valid || prev_fire);
            exp_br = fresh && (q.size() != 0) && q[0].br;
            n_checks++;
            if (branch_o !== exp_br) begin
                n_fail++;
                $display("FAIL rnd_branch cyc %0d: got %b required %b", cyc, branch_o, exp_br);
            end
            if (exp_br) begin
                n_checks++;
                if (branch_target_o !== q[0].tgt) begin
                    n_fail++;
                    $display("FAIL rnd_target cyc %0d: got %h required %h", cyc, branch_target_o, q[0].tgt);
                end
            end
            input_valid_i      = ($urandom_range(0, 3) != 0);
            output_ready_i     = ($urandom_range(0, 3) != 0);
            alu_op_i           = 3'($urandom_range(0, 7));
            alu_sub_i          = 1'($urandom);
            alu_shift_left_i   = 1'($urandom);
            alu_signed_shift_i = 1'($urandom);
            alu_operand1_i     = $urandom;
            alu_operand2_i     = ($urandom_range(0, 3) == 0) ? alu_operand1_i : $urandom;
            branch_cond_i      = 3'($urandom_range(0, 7));
            pc_i               = $urandom;
            branch_offset_i    = $urandom;
            ls_enable_i        = 1'($urandom);
            ls_write_i         = 1'($urandom);
            ls_write_data_i    = $urandom;
            ls_sel_i           = 4'($urandom);
            ls_unsigned_load_i = 1'($urandom);
            reg_write_i        = 1'($urandom);
            reg_addr_i         = 5'($urandom);
            #1;
            acc  = input_valid_i & input_ready_o;
            fire = output_valid_o & output_ready_i;
            if (fire) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_spurious cyc %0d: got fire with empty model required no output", cyc);
                end else begin
                    if (out_payload() !== q[0].payload) begin
                        n_fail++;
                        $display("FAIL rnd_payload cyc %0d: got %h required %h", cyc, out_payload(), q[0].payload);
                    end
                    $display("tx %0d: result=%h reg=%0d", n_tx, alu_result_o, reg_addr_o);
                    n_tx++;
                    void'(q.pop_front());
                end
            end
            if (acc) begin
                e.payload = model_payload();
                e.br      = model_branch(branch_cond_i, alu_operand1_i, alu_operand2_i);
                e.tgt     = pc_i + branch_offset_i;
                q.push_back(e);
            end
            prev_valid = output_valid_o;
            prev_fire  = fire;
            @(negedge clk_i);
        end
        input_valid_i  = 1'b0;
        output_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i              = 1'b0;
        input_valid_i      = 1'b0;
        pc_i               = 32'd0;
        alu_operand1_i     = 32'd0;
        alu_operand2_i     = 32'd0;
        alu_op_i           = 3'd0;
        alu_sub_i          = 1'b0;
        alu_shift_left_i   = 1'b0;
        alu_signed_shift_i = 1'b0;
        branch_cond_i      = 3'd0;
        branch_offset_i    = 32'd0;
        ls_enable_i        = 1'b0;
        ls_write_i         = 1'b0;
        ls_write_data_i    = 32'd0;
        ls_sel_i           = 4'd0;
        ls_unsigned_load_i = 1'b0;
        reg_write_i        = 1'b0;
        reg_addr_i         = 5'd0;
        output_ready_i     = 1'b1;

        test_reset();
        test_add_wrap();
        test_shift();
        test_slt();
        test_branch();
        test_stall();
        test_reset_mid_stall();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
